sad_argmin_stream: RTL and testbench

SAD_ARGMIN_STREAM -- requirements
Module: sad_argmin_stream

---
 rtl/sad_argmin_stream.sv | 138 +++++++++++++
 tb/tb_sad_argmin_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sad_argmin_stream.sv
// Streaming SAD arg-min: finds the smallest SAD in each block of candidates
// and reports its value, index and {row,col} motion vector with an elastic output hold.
module sad_argmin_stream #(
  parameter int SAD_W  = 12,
  parameter int N_CAND = 16,
  parameter int COLS   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SAD_W-1:0] in_sad,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] out_sad,
  output logic [7:0]       out_mv,
  output logic [7:0]       out_idx,
  output logic             out_err
);

  localparam int CNT_W = $clog2(N_CAND + 1);
  localparam logic [CNT_W-1:0] N_CAND_C = CNT_W'(N_CAND);
  localparam logic [7:0]       COLS_C   = 8'(COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [CNT_W-1:0] cnt_r, cnt_inc_s;
  logic [SAD_W-1:0] min_sad_r, min_sad_nxt_s;
  logic [7:0]       min_idx_r, min_idx_nxt_s;
  logic             out_valid_r;
  logic [SAD_W-1:0] out_sad_r;
  logic [7:0]       out_mv_r, out_idx_r;
  logic             out_err_r;

  logic       in_ready_s, beat_s, first_s, close_s, err_s, full_s;
  logic [3:0] row_s, col_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a beat taken in HOLD is the first beat of a new block.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (beat_s) state_nxt_s = close_s ? HOLD : ACCUM;
        else        state_nxt_s = IDLE;
      end
      ACCUM: begin
        if (close_s) state_nxt_s = HOLD;
        else         state_nxt_s = ACCUM;
      end
      HOLD: begin
        if (beat_s)         state_nxt_s = close_s ? HOLD : ACCUM;
        else if (out_ready) state_nxt_s = IDLE;
        else                state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/strobe logic: handshake, close detection and the running minimum.
  always_comb begin
    in_ready_s    = !out_valid_r || out_ready;
    beat_s        = in_valid && in_ready_s;
    first_s       = (state_r != ACCUM);
    cnt_inc_s     = first_s ? {{(CNT_W-1){1'b0}}, 1'b1} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    full_s        = (cnt_inc_s == N_CAND_C);
    close_s       = beat_s && (in_last || full_s);
    // Error when the closing reason is exactly one of in_last / full count.
    err_s         = (in_last != full_s);
    min_sad_nxt_s = min_sad_r;
    min_idx_nxt_s = min_idx_r;
    if (first_s) begin
      min_sad_nxt_s = in_sad;
      min_idx_nxt_s = 8'd0;
    end else if (in_sad < min_sad_r) begin
      min_sad_nxt_s = in_sad;
      min_idx_nxt_s = 8'(cnt_r);
    end else begin
      min_sad_nxt_s = min_sad_r;
      min_idx_nxt_s = min_idx_r;
    end
    row_s = 4'(min_idx_nxt_s / COLS_C);
    col_s = 4'(min_idx_nxt_s % COLS_C);
  end

  // Accumulator and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      min_sad_r   <= {SAD_W{1'b0}};
      min_idx_r   <= 8'd0;
      out_valid_r <= 1'b0;
      out_sad_r   <= {SAD_W{1'b0}};
      out_mv_r    <= 8'd0;
      out_idx_r   <= 8'd0;
      out_err_r   <= 1'b0;
    end else begin
      if (beat_s) begin
        min_sad_r <= min_sad_nxt_s;
        min_idx_r <= min_idx_nxt_s;
      end
      if (close_s) begin
        cnt_r       <= {CNT_W{1'b0}};
        out_valid_r <= 1'b1;
        out_sad_r   <= min_sad_nxt_s;
        out_idx_r   <= min_idx_nxt_s;
        out_mv_r    <= {row_s, col_s};
        out_err_r   <= err_s;
      end else begin
        if (beat_s) cnt_r <= cnt_inc_s;
        if (out_valid_r && out_ready) out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_sad   = out_sad_r;
  assign out_mv    = out_mv_r;
  assign out_idx   = out_idx_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_sad_argmin_stream.sv
// Directed self-checking bench for sad_argmin_stream (default and 16/64/8 parameter sets).
module tb_sad_argmin_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_err;
  logic [11:0] in_sad, out_sad;
  logic [7:0]  out_mv, out_idx;

  logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_err2;
  logic [15:0] in_sad2, out_sad2;
  logic [7:0]  out_mv2, out_idx2;

  logic [11:0] blk [16];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sad_argmin_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sad(in_sad), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sad(out_sad), .out_mv(out_mv), .out_idx(out_idx), .out_err(out_err)
  );

  sad_argmin_stream #(.SAD_W(16), .N_CAND(64), .COLS(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sad(in_sad2), .in_last(in_last2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sad(out_sad2), .out_mv(out_mv2), .out_idx(out_idx2), .out_err(out_err2)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input logic [11:0] sad, input logic last);
    in_valid = 1'b1; in_sad = sad; in_last = last;
    tick();
  endtask

  task automatic stream_blk(input int n, input logic use_last);
    for (int i = 0; i < n; i++) drive_beat(blk[i], use_last && (i == n - 1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_sad = 12'd0;
    in_valid2 = 1'b0; in_last2 = 1'b0; in_sad2 = 16'd0; out_ready2 = 1'b1;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_mv, out_err} !== {1'b0, 12'd0, 8'd0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_outputs: got v=%b sad=%0d idx=%0d mv=%h err=%b expected all zero",
                        out_valid, out_sad, out_idx, out_mv, out_err);
    end
    rst_n = 1'b1; tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 9; i++) blk[i] = 12'(100 - 10 * i);
    blk[9] = 12'd5;
    for (int k = 0; k < 6; k++) blk[10 + k] = 12'(10 * (k + 1));
    stream_blk(16, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_sad !== 12'd5) begin n_fail++; $display("FAIL basic_sad: got %0d expected 5", out_sad); end
    n_checks++; if (out_idx !== 8'd9) begin n_fail++; $display("FAIL basic_idx: got %0d expected 9", out_idx); end
    n_checks++; if (out_mv !== 8'h21) begin n_fail++; $display("FAIL basic_mv: got %h expected 21", out_mv); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", out_err); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b expected 0", out_valid); end
  endtask

  task automatic test_ties();
    for (int i = 0; i < 16; i++) blk[i] = 12'd7;
    stream_blk(16, 1'b1);
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_mv} !== {1'b1, 12'd7, 8'd0, 8'h00}) begin
      n_fail++; $display("FAIL ties_all_equal: got v=%b sad=%0d idx=%0d mv=%h expected v=1 sad=7 idx=0 mv=00",
                        out_valid, out_sad, out_idx, out_mv);
    end
    tick();
    for (int i = 0; i < 16; i++) blk[i] = 12'd9;
    blk[6] = 12'd3; blk[13] = 12'd3;
    stream_blk(16, 1'b1);
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_mv} !== {1'b1, 12'd3, 8'd6, 8'h12}) begin
      n_fail++; $display("FAIL ties_two_min: got v=%b sad=%0d idx=%0d mv=%h expected v=1 sad=3 idx=6 mv=12",
                        out_valid, out_sad, out_idx, out_mv);
    end
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 9; i++) blk[i] = 12'(100 - 10 * i);
    blk[9] = 12'd5;
    for (int k = 0; k < 6; k++) blk[10 + k] = 12'(10 * (k + 1));
    out_ready = 1'b0;
    stream_blk(16, 1'b1);
    // A single-beat block of SAD 1 is offered while stalled; it must be ignored.
    in_valid = 1'b1; in_sad = 12'd1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({in_ready, out_valid, out_sad, out_idx, out_mv, out_err} !== {1'b0, 1'b1, 12'd5, 8'd9, 8'h21, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b sad=%0d idx=%0d mv=%h err=%b expected rdy=0 v=1 sad=5 idx=9 mv=21 err=0",
                          c, in_ready, out_valid, out_sad, out_idx, out_mv, out_err);
      end
      tick();
    end
    out_ready = 1'b1; in_sad = 12'd50; in_last = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    drive_beat(12'd50, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_drop: got %b expected 0", out_valid); end
    for (int i = 1; i < 16; i++) drive_beat(12'd60, i == 15);
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_err} !== {1'b1, 12'd50, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL bp_next_block: got v=%b sad=%0d idx=%0d err=%b expected v=1 sad=50 idx=0 err=0",
                        out_valid, out_sad, out_idx, out_err);
    end
    tick();
  endtask

  task automatic test_length_err();
    blk[0] = 12'd9; blk[1] = 12'd8; blk[2] = 12'd7; blk[3] = 12'd2;
    stream_blk(4, 1'b1);
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_mv, out_err} !== {1'b1, 12'd2, 8'd3, 8'h03, 1'b1}) begin
      n_fail++; $display("FAIL short_block: got v=%b sad=%0d idx=%0d mv=%h err=%b expected v=1 sad=2 idx=3 mv=03 err=1",
                        out_valid, out_sad, out_idx, out_mv, out_err);
    end
    tick();
    for (int i = 0; i < 16; i++) blk[i] = 12'(20 + i);
    blk[12] = 12'd4;
    stream_blk(16, 1'b0);
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_mv, out_err} !== {1'b1, 12'd4, 8'd12, 8'h30, 1'b1}) begin
      n_fail++; $display("FAIL no_last_block: got v=%b sad=%0d idx=%0d mv=%h err=%b expected v=1 sad=4 idx=12 mv=30 err=1",
                        out_valid, out_sad, out_idx, out_mv, out_err);
    end
    tick();
    drive_beat(12'd33, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_err} !== {1'b1, 12'd33, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL single_beat: got v=%b sad=%0d idx=%0d err=%b expected v=1 sad=33 idx=0 err=1",
                        out_valid, out_sad, out_idx, out_err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_beat(12'd11, 1'b1);
    n_checks++; if ({out_valid, out_sad} !== {1'b1, 12'd11}) begin
      n_fail++; $display("FAIL b2b_first: got v=%b sad=%0d expected v=1 sad=11", out_valid, out_sad); end
    drive_beat(12'd22, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if ({out_valid, out_sad} !== {1'b1, 12'd22}) begin
      n_fail++; $display("FAIL b2b_second: got v=%b sad=%0d expected v=1 sad=22", out_valid, out_sad); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) blk[i] = 12'd50;
    blk[2] = 12'd1;
    stream_blk(8, 1'b0);
    rst_n = 1'b0; tick();
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL mid_rst_during: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid); end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++; $display("FAIL mid_rst_after[%0d]: got rdy=%b v=%b expected rdy=1 v=0", c, in_ready, out_valid); end
    end
    for (int i = 0; i < 16; i++) blk[i] = 12'(40 + i);
    blk[4] = 12'd12;
    stream_blk(16, 1'b1);
    n_checks++;
    if ({out_valid, out_sad, out_idx, out_mv, out_err} !== {1'b1, 12'd12, 8'd4, 8'h10, 1'b0}) begin
      n_fail++; $display("FAIL mid_rst_fresh: got v=%b sad=%0d idx=%0d mv=%h err=%b expected v=1 sad=12 idx=4 mv=10 err=0",
                        out_valid, out_sad, out_idx, out_mv, out_err);
    end
    tick();
    out_ready = 1'b0;
    blk[0] = 12'd9; blk[1] = 12'd8; blk[2] = 12'd7; blk[3] = 12'd2;
    stream_blk(4, 1'b1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++; $display("FAIL hold_rst[%0d]: got rdy=%b v=%b expected rdy=1 v=0", c, in_ready, out_valid); end
    end
  endtask

  task automatic test_params();
    n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL p2_ready: got %b expected 1", in_ready2); end
    for (int i = 0; i < 64; i++) begin
      in_valid2 = 1'b1;
      in_sad2   = (i == 63) ? 16'hFFFE : 16'hFFFF;
      in_last2  = (i == 63);
      tick();
    end
    in_valid2 = 1'b0; in_last2 = 1'b0;
    n_checks++;
    if ({out_valid2, out_sad2, out_idx2, out_mv2, out_err2} !== {1'b1, 16'hFFFE, 8'd63, 8'h77, 1'b0}) begin
      n_fail++; $display("FAIL p2_result: got v=%b sad=%h idx=%0d mv=%h err=%b expected v=1 sad=fffe idx=63 mv=77 err=0",
                        out_valid2, out_sad2, out_idx2, out_mv2, out_err2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_length_err();
    test_back_to_back();
    test_reset_mid();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
